// File: rtl/address_stepper_if.sv
// address_stepper_if: handshake between the stepper and the downstream ROM reader
interface address_stepper_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  ready;
  logic [ADDR_WIDTH-1:0] address;
  logic                  step;
  logic                  pending;
  modport master(input ready, output address, step, pending);
  modport slave(output ready, input address, step, pending);
endinterface

// File: rtl/address_stepper.sv
// address_stepper: debounced push-button with auto-repeat that steps an instruction address
module address_stepper #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12000000,
  parameter int REPEAT_PERIOD   = 3000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn,
  address_stepper_if.master     bus
);
  localparam int CMAX_A = DEBOUNCE_CYCLES > REPEAT_PERIOD ? DEBOUNCE_CYCLES : REPEAT_PERIOD;
  localparam int CMAX   = CMAX_A > REPEAT_DELAY ? CMAX_A : REPEAT_DELAY;
  localparam int CW     = $clog2(CMAX + 1) + 1;
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY > 0 ? REPEAT_DELAY - 1 : 0);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE} state_t;
  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  sync1_q, btn_s_q;
  logic                  req;
  logic [ADDR_WIDTH-1:0] address_q;
  logic                  step_q, pending_q;
  // two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {sync1_q, btn_s_q} <= 2'b00;
    else {sync1_q, btn_s_q} <= {btn, sync1_q};
  end
  // step request: debounce complete, repeat delay elapsed, or repeat period elapsed (button still held)
  always_comb
    req = btn_s_q && ((state_q == DB_PRESS && cnt_q == DB_LAST) ||
                      (state_q == HELD && REPEAT_DELAY > 0 && cnt_q == RD_LAST) ||
                      (state_q == REPEAT && cnt_q == RP_LAST));
  // button FSM with one shared counter, cleared on every state entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (btn_s_q) state_q <= DB_PRESS;
        end
        DB_PRESS:
          if (!btn_s_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        HELD:
          if (!btn_s_q) begin
            state_q <= DB_RELEASE;
            cnt_q   <= '0;
          end else if (REPEAT_DELAY > 0 && cnt_q == RD_LAST) begin
            state_q <= REPEAT;
            cnt_q   <= '0;
          end else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        REPEAT:
          if (!btn_s_q) begin
            state_q <= DB_RELEASE;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q == RP_LAST ? '0 : cnt_q + 1'b1;
        DB_RELEASE:
          if (btn_s_q) cnt_q <= '0;
          else if (cnt_q == DB_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end
  // single outstanding step: requests merge into pending, ready consumes it into an address increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q <= '0;
      step_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      step_q    <= pending_q && bus.ready;
      pending_q <= req || (pending_q && !bus.ready);
      if (pending_q && bus.ready) address_q <= address_q + 1'b1;
    end
  end
  assign bus.address = address_q;
  assign bus.step    = step_q;
  assign bus.pending = pending_q;
endmodule

// File: tb/tb_address_stepper.sv
// tb_address_stepper: table-driven press vectors plus a step scoreboard and multi-cycle corner sequences
module tb_address_stepper;
  localparam int AW = 4;
  typedef struct {int edge_n; logic [AW-1:0] addr;} exp_t;
  typedef struct {int hi; int n; int e[6];} vec_t;
  logic clk = 1'b0, reset = 1'b1, btn = 1'b0, rdy = 1'b1;
  int cyc = 0, base = 0, checks = 0, errors = 0;
  logic [AW-1:0] exp_addr = '0;
  exp_t sbq[$];
  exp_t mx;
  vec_t vecs[6];
  address_stepper_if #(.ADDR_WIDTH(AW)) bus();
  assign bus.ready = rdy;
  address_stepper #(.ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .clk(clk), .reset(reset), .btn(btn), .bus(bus.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int rel();
    return cyc - base - 1;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (edge %0d)", name, act, exp, rel());
    end
  endtask
  task automatic expect_step(input int e);
    exp_addr = exp_addr + 1'b1;
    sbq.push_back('{e, exp_addr});
  endtask
  task automatic start_press();
    @(negedge clk);
    base = cyc;
    btn = 1'b1;
  endtask
  task automatic press(input int hi, input int idle);
    start_press();
    repeat (hi) @(negedge clk);
    btn = 1'b0;
    repeat (idle) @(negedge clk);
  endtask
  task automatic q_empty(input string name);
    chk(name, sbq.size(), 0);
    sbq.delete();
  endtask
  // scoreboard: every step pulse must match the next expected edge and address
  always @(negedge clk) begin
    if (!reset && bus.step) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step edge=%0d addr=%0d", rel(), bus.address);
      end else begin
        mx = sbq.pop_front();
        if (mx.edge_n != rel() || mx.addr != bus.address) begin
          errors++;
          $display("FAIL step got edge=%0d addr=%0d want edge=%0d addr=%0d", rel(), bus.address, mx.edge_n, mx.addr);
        end
      end
    end
  end
  initial begin
    vecs[0] = '{3, 0, '{0, 0, 0, 0, 0, 0}};
    vecs[1] = '{4, 0, '{0, 0, 0, 0, 0, 0}};
    vecs[2] = '{5, 1, '{7, 0, 0, 0, 0, 0}};
    vecs[3] = '{24, 1, '{7, 0, 0, 0, 0, 0}};
    vecs[4] = '{25, 2, '{7, 27, 0, 0, 0, 0}};
    vecs[5] = '{60, 6, '{7, 27, 35, 43, 51, 59}};
    repeat (3) @(negedge clk);
    chk("reset_address", bus.address, 0);
    chk("reset_step", bus.step, 0);
    chk("reset_pending", bus.pending, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    expect_step(7);
    start_press();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i <= 10) chk("v1_pending", bus.pending, rel() == 6 ? 1 : 0);
    end
    btn = 1'b0;
    repeat (20) @(negedge clk);
    q_empty("v1_steps_left");
    chk("v1_address", bus.address, 1);
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].n; k++) expect_step(vecs[v].e[k]);
      press(vecs[v].hi, 25);
      q_empty($sformatf("vec%0d_steps_left", v));
      chk($sformatf("vec%0d_address", v), bus.address, exp_addr);
      chk($sformatf("vec%0d_pending", v), bus.pending, 0);
    end
    rdy = 1'b0;
    start_press();
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    while (rel() < 60) @(negedge clk);
    chk("v3_pending_stalled", bus.pending, 1);
    chk("v3_address_stalled", bus.address, exp_addr);
    expect_step(61);
    rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("v3_pending_after", bus.pending, 0);
    repeat (20) @(negedge clk);
    q_empty("v3_steps_left");
    chk("v3_address", bus.address, exp_addr);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_addr = '0;
    chk("v5_address_reset", bus.address, 0);
    for (int i = 0; i < 17; i++) begin
      expect_step(7);
      press(8, 12);
    end
    q_empty("v5_steps_left");
    chk("v5_address_wrapped", bus.address, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_addr = '0;
    expect_step(7);
    expect_step(27);
    expect_step(35);
    start_press();
    while (rel() < 39) @(negedge clk);
    chk("v6_address_before", bus.address, 3);
    q_empty("v6_steps_before");
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("v6_address_in_reset", bus.address, 0);
    chk("v6_step_in_reset", bus.step, 0);
    chk("v6_pending_in_reset", bus.pending, 0);
    @(negedge clk);
    reset = 1'b0;
    base = cyc;
    exp_addr = '0;
    expect_step(7);
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (25) @(negedge clk);
    q_empty("v6_steps_after");
    chk("v6_address_after", bus.address, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/address_stepper.md
ADDRESS_STEPPER -- requirements
Module: address_stepper

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: width of the address output.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable synchronized-input cycles required to accept a press or a release; legal range 1 or more.
REQ-003 Parameter REPEAT_DELAY, default 12000000: cycles held in HELD before auto-repeat starts; 0 disables auto-repeat.
REQ-004 Parameter REPEAT_PERIOD, default 3000000: cycles between auto-repeat requests; legal range 1 or more.
REQ-005 Port clk, input, 1: single system clock; every register is clocked on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port btn, input, 1: raw push-button level, asynchronous to clk, active-high.
REQ-008 Port ready, input, 1: the downstream ROM reader can accept a new address.
REQ-009 Port address, output, ADDR_WIDTH: current instruction address, registered.
REQ-010 Port step, output, 1: one-cycle pulse, high in the cycle in which address holds a newly incremented value.
REQ-011 Port pending, output, 1: a step request has been accepted and is waiting for ready.

Function
REQ-012 btn SHALL pass through a 2-flop synchronizer; the FSM and counters SHALL see only the second flop output (btn_s).
REQ-013 FSM states SHALL be IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE, with one shared counter cnt that is cleared on every state entry.
REQ-014 IDLE: btn_s=1 -> DB_PRESS.
REQ-015 DB_PRESS: btn_s=0 -> IDLE, with no request.
REQ-016 DB_PRESS: btn_s=1 and cnt=DEBOUNCE_CYCLES-1 -> HELD, and raise a request.
REQ-017 DB_PRESS: otherwise cnt increments.
REQ-018 HELD: btn_s=0 -> DB_RELEASE.
REQ-019 HELD: REPEAT_DELAY>0 and cnt=REPEAT_DELAY-1 -> REPEAT, and raise a request.
REQ-020 HELD: otherwise cnt increments; cnt saturates when REPEAT_DELAY=0.
REQ-021 REPEAT: btn_s=0 -> DB_RELEASE.
REQ-022 REPEAT: cnt=REPEAT_PERIOD-1 -> raise a request and clear cnt.
REQ-023 REPEAT: otherwise cnt increments.
REQ-024 DB_RELEASE: btn_s=1 clears cnt and stays in DB_RELEASE (bounce restarts the count).
REQ-025 DB_RELEASE: btn_s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE.
REQ-026 A request SHALL set pending; a request while pending=1 SHALL be merged, so at most one step is outstanding.
REQ-027 On an edge with pending=1 and ready=1: address <= address+1 modulo 2^ADDR_WIDTH (all-ones wraps to 0); step <= 1; pending <= 0.
REQ-028 A request on the same edge as a consumption SHALL leave pending=1.
REQ-029 step SHALL be 0 on every other edge.
REQ-030 address SHALL change only as stated in REQ-027.
REQ-031 Latency with ready held high and btn rising before edge 0: pending rises at edge DEBOUNCE_CYCLES+2, and address/step update at edge DEBOUNCE_CYCLES+3.
REQ-032 ready=0 SHALL stall consumption indefinitely without losing the pending request.

Reset
REQ-033 While reset=1 (asynchronously): address=0, step=0, pending=0, synchronizer flops=0, cnt=0, state=IDLE.
REQ-034 After reset deasserts with btn still held, a full new debounce SHALL occur before any step.

Verification
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; edge 0 is the first edge sampling btn=1.
V1 Clean press: ready=1, btn high 15 cycles then low -> exactly one step, at edge 7; address 0->1; pending high for edge 6 to edge 7 only.
V2 Glitch: btn high for 3 cycles -> no step; address stays 0; state returns to IDLE.
V3 Stall: ready=0, two debounced presses, ready raised at edge 60 -> single step at edge 61; address=1; pending=0 afterwards.
V4 Auto-repeat: ready=1, btn held 60 cycles -> steps at edges 7, 27, 35, 43, 51, 59; address=6.
V5 Wrap: ADDR_WIDTH=4, ready=1, 17 debounced presses -> address sequence 1..15, 0, 1; step pulses on each increment.
V6 Reset mid-repeat: reset asserted at edge 40 while btn stays high -> address=0 and step=0 immediately; first new step 7 edges after reset release.
